// File: rtl/led_strip_driver.sv
// ---------------------------------------------------------------------------
// led_strip_driver
//
// Serial transmitter for chains of clocked-serial RGB LEDs (SDI/CKI parts).
// Pixels arrive one at a time over a valid/ready handshake, are reordered
// into the strip's color order, and are shifted out MSB-first on SDO with a
// divided clock on CKO. After the last pixel of a frame, CKO is held low for
// LATCH_CYCLES clocks so the strip latches. If the source stalls for that
// long mid-frame, the strip latches a partial frame. The driver reports this
// as an underrun and starts a new frame with the next pixel.
//
// Parameters
//   LEDS         pixels per frame
//   BPC          bits per color channel, pixel width W = 3*BPC
//   CLK_DIV      system clocks per CKO half-period
//   LATCH_CYCLES CKO-low system clocks that latch the strip
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pixel        {R,G,B} pixel, R in the MSBs
//   pixel_valid  upstream has a pixel
//   pixel_ready  driver accepts pixel this cycle (IDLE or WAIT)
//   order        color order, sampled on accept: 0 RGB, 1 GRB, 2 BRG, 3 RGB
//   SDO          serial data to the first LED
//   CKO          serial clock to the first LED
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the latch gap completes
//   underrun     one-cycle pulse when a frame is aborted by a pixel gap
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in progress, ready for the first pixel of a frame
// SHIFT | serializing the current pixel, low phase then high phase per bit
// WAIT  | between pixels of a frame, CKO low, counting the gap
// LATCH | frame complete, CKO and SDO low for LATCH_CYCLES clocks
// ---------------------------------------------------------------------------
module led_strip_driver #(
   parameter int LEDS         = 5,
   parameter int BPC          = 8,
   parameter int CLK_DIV      = 2,
   parameter int LATCH_CYCLES = 6250
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3*BPC-1:0]   pixel,
   input  logic               pixel_valid,
   output logic               pixel_ready,
   input  logic [1:0]         order,
   output logic               SDO,
   output logic               CKO,
   output logic               busy,
   output logic               done,
   output logic               underrun
);

   localparam int W     = 3 * BPC;
   localparam int BIT_W = $clog2(W);
   localparam int PIX_W = $clog2(LEDS + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(LATCH_CYCLES + 1);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
   localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
   localparam logic [PIX_W-1:0] PIX_LEDS = PIX_W'(LEDS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LATCH_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       shreg_q, shreg_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               phase_q, phase_d;     // 0 = low phase, 1 = high phase
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               sdo_q, sdo_d;
   logic               cko_q, cko_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               underrun_q, underrun_d;

   logic [BPC-1:0]     r_ch, g_ch, b_ch;
   logic [W-1:0]       reord;
   logic               accept;
   logic               load;

   assign r_ch = pixel[3*BPC-1 -: BPC];
   assign g_ch = pixel[2*BPC-1 -: BPC];
   assign b_ch = pixel[BPC-1:0];

   // First transmitted channel goes to the MSBs of the shift register.
   always_comb begin
      reord = {r_ch, g_ch, b_ch};
      case (order)
         2'd1:    reord = {g_ch, r_ch, b_ch};
         2'd2:    reord = {b_ch, r_ch, g_ch};
         default: reord = {r_ch, g_ch, b_ch};
      endcase
   end

   assign accept = pixel_valid & ready_q;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      phase_d    = phase_q;
      div_cnt_d  = div_cnt_q;
      pix_cnt_d  = pix_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      sdo_d      = sdo_q;
      cko_d      = cko_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) load = 1'b1;
         end

         WAIT: begin
            if (accept) begin
               load = 1'b1;
            end else if (gap_cnt_q == GAP_LAST) begin
               // Strip has already latched what it received; restart the frame.
               state_d    = IDLE;
               underrun_d = 1'b1;
               pix_cnt_d  = '0;
               gap_cnt_d  = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_ONE;
            end
         end

         SHIFT: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - DIV_ONE;
            end else begin
               div_cnt_d = DIV_LAST;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  cko_d   = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  cko_d   = 1'b0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
                     gap_cnt_d = '0;
                     if (pix_cnt_q < PIX_LEDS) begin
                        state_d = WAIT;
                     end else begin
                        state_d = LATCH;
                        sdo_d   = 1'b0;
                     end
                  end else begin
                     // Rotate rather than shift so every register bit stays in use;
                     // the wrapped bit is never transmitted.
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     shreg_d   = {shreg_q[W-2:0], shreg_q[W-1]};
                     sdo_d     = shreg_q[W-2];
                  end
               end
            end
         end

         LATCH: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               pix_cnt_d = '0;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_ONE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (load) begin
         state_d   = SHIFT;
         shreg_d   = reord;
         sdo_d     = reord[W-1];
         cko_d     = 1'b0;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         div_cnt_d = DIV_LAST;
         pix_cnt_d = pix_cnt_q + PIX_ONE;
         gap_cnt_d = '0;
      end
   end

   // Status outputs are registered from the next state so they line up with it.
   always_comb begin
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE) || (state_d == WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         phase_q    <= 1'b0;
         div_cnt_q  <= '0;
         pix_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         sdo_q      <= 1'b0;
         cko_q      <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         phase_q    <= phase_d;
         div_cnt_q  <= div_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         sdo_q      <= sdo_d;
         cko_q      <= cko_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign pixel_ready = ready_q;
   assign SDO         = sdo_q;
   assign CKO         = cko_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign underrun    = underrun_q;

endmodule

// File: doc/led_strip_driver.md
# led_strip_driver

Synthesizable transmitter for chains of clocked-serial RGB LEDs (SDI/CKI devices that shift color data MSB-first on rising CKI, pass later data downstream, and latch after a long CKI-low gap). It accepts one pixel at a time from an upstream frame source over a valid/ready handshake, serializes each pixel onto `SDO`/`CKO` with a programmable clock divider, and enforces the latch gap after the last pixel. It sits between the pixel pipeline and the first `LEDModel`-compatible device of the strip, and generalises the single fixed 24-bit LED format to any strip length, channel depth and color order.

## Interface
- `LEDS`, 5: pixels per frame (≥1)
- `BPC`, 8: bits per color channel (≥1); pixel width `W = 3*BPC`
- `CLK_DIV`, 2: system clocks per CKO half-period (≥1)
- `LATCH_CYCLES`, 6250: CKO-low system clocks that latch the strip (≥1; 6250 = 500 µs at 12.5 MHz)

- `clk` in 1: system clock; one clock domain; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `pixel` in W: pixel data `{R,G,B}`, R in MSBs
- `pixel_valid` in 1: upstream has a pixel
- `pixel_ready` out 1: driver accepts `pixel` this cycle
- `order` in 2: color order, sampled on accept: 0 RGB, 1 GRB, 2 BRG, 3 treated as RGB
- `SDO` out 1: serial data to the first LED's SDI
- `CKO` out 1: serial clock to the first LED's CKI
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the latch gap completes
- `underrun` out 1: one-cycle pulse when a frame is aborted by a pixel gap

## Operation
- States: IDLE, SHIFT, WAIT, LATCH.
- Accept = `pixel_valid & pixel_ready`. `pixel_ready` = 1 in IDLE and WAIT only, and is a function of state alone.
- On accept, reorder the pixel per `order` into a W-bit shift register (first transmitted channel in the MSBs), increment the pixel counter, and go to SHIFT.
- SHIFT sends W bits MSB-first. Each bit is a low phase followed by a high phase:
  - Low phase: CLK_DIV cycles with `SDO` = current bit and `CKO` = 0.
  - High phase: CLK_DIV cycles with `CKO` = 1 and `SDO` held.
  - Then shift left by one.
- After the high phase of bit W-1, `CKO` returns to 0:
  - If pixel count < LEDS, go to WAIT.
  - Otherwise go to LATCH.
- WAIT holds `CKO` = 0 and `SDO` unchanged. The gap counter increments every WAIT cycle without an accept.
  - If an accept occurs, go to SHIFT.
  - If the gap counter reaches LATCH_CYCLES, pulse `underrun`, clear the pixel counter and go to IDLE. The strip has latched a partial frame, so the next pixel starts a new frame.
- LATCH holds `CKO` = 0 and `SDO` = 0 for LATCH_CYCLES cycles, then pulses `done`, clears the pixel counter and goes to IDLE.
- Accept while in IDLE starts a new frame. `pixel_valid` while not ready is ignored; the driver never drops a pixel.
- Reset (asynchronous, any time including mid-bit or mid-LATCH): state IDLE; all counters 0; `SDO` = 0, `CKO` = 0, `busy` = 0, `done` = 0, `underrun` = 0. `pixel_ready` = 1 once `rst` deasserts.
- Counter widths: bit counter `$clog2(W)`, pixel counter `$clog2(LEDS+1)`, divider `$clog2(CLK_DIV)` (minimum 1), latch/gap counter `$clog2(LATCH_CYCLES+1)`. All are unsigned and never wrap within legal operation.

## Timing
- All outputs are registered.
- Accept at edge k: `busy` = 1 and `SDO` = bit W-1 from edge k+1, with `CKO` = 0 during cycles k+1 … k+CLK_DIV.
- `CKO` rises at edge k+1+CLK_DIV. One bit period = 2·CLK_DIV cycles; one pixel = 2·CLK_DIV·W cycles.
- `SDO` changes only while `CKO` = 0, and at least CLK_DIV cycles before each rising `CKO`. This gives setup and hold of CLK_DIV cycles.
- Last pixel's final `CKO` fall at edge f: `done` is high in the cycle after edge f+LATCH_CYCLES, and `busy` falls together with `done`. A new accept is possible in that same cycle.
- Back-to-back pixels with `pixel_valid` held high: WAIT lasts exactly 1 cycle, so the low phase of a pixel's first bit is CLK_DIV+1 cycles.
- `done` and `underrun` are never high in the same cycle.

## Test plan
- LEDS=5, BPC=8, CLK_DIV=2, LATCH_CYCLES=100, `order`=0, five pixels 24'hFFFFFF streamed back-to-back into a chain of five LEDModels → 120 rising CKO edges. Every `rgb` = FFFFFF after the latch gap, with `done` pulsing once 100 cycles after the last CKO fall.
- Same setup, pixels AAAAAA, 555555, F0F0F0, 0F0F0F, FFF000 → LED0..LED4 latch exactly those values in that order. SDO is stable across every CKO rising edge.
- `order`=1 with pixel 24'h112233 → first 24 SDO bits decode to 22 11 33. `order`=2 → 33 11 22. `order`=3 → 11 22 33.
- Two pixels sent, then `pixel_valid` low for 100 cycles → `underrun` pulses, `busy` drops, LED0/LED1 hold the two pixels. A following 5-pixel frame completes normally.
- Assert `rst` mid-bit of pixel 3 → `SDO`/`CKO`/`busy` go to 0 immediately (asynchronously). After release, `pixel_ready` = 1 and a fresh 5-pixel frame latches correctly.
- BPC=4, LEDS=1, CLK_DIV=1 → 12 CKO pulses, each 1 cycle high and 1 cycle low. `done` fires LATCH_CYCLES after the 12th fall.
